// File: rtl/read_write_if.sv
// Controller/memory bus for the read_write sequencer: request, address and data lines
// from the controller, plus the command, address and data lines toward the pixel SRAM.
interface read_write_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start_read;
  logic              start_write;
  logic [ADDR_W-1:0] addr_r_mc;
  logic [ADDR_W-1:0] addr_w_mc;
  logic [DATA_W-1:0] data_w;
  logic [DATA_W-1:0] data_r;
  logic              busy;
  logic [1:0]        instruction;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] data_w_o;
  logic [DATA_W-1:0] data_r_o;
  logic              write_done;

  modport master (
    output start_read, start_write, addr_r_mc, addr_w_mc, data_w, data_r, busy,
    input  instruction, addr_r, addr_w, data_w_o, data_r_o, write_done
  );

  modport slave (
    input  start_read, start_write, addr_r_mc, addr_w_mc, data_w, data_r, busy,
    output instruction, addr_r, addr_w, data_w_o, data_r_o, write_done
  );
endinterface

// File: rtl/read_write.sv
// Memory-access sequencer: turns level-held read/write requests into one SRAM command,
// waiting on busy, returning read data and pulsing write_done on write completion.
module read_write #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  read_write_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_WAIT, RD_HOLD, WR_CMD, WR_WAIT, WR_HOLD
  } state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            state, state_nxt;
  logic              ld_rd, ld_wr, cap_rd, pulse_wr;
  logic [1:0]        instr_q;
  logic [ADDR_W-1:0] addr_r_q, addr_w_q;
  logic [DATA_W-1:0] data_w_q, data_r_q;
  logic              write_done_q;

  // Command code is a pure function of the state, registered from the next state
  function automatic logic [1:0] cmd_of(input state_t s);
    case (s)
      RD_CMD, RD_WAIT, RD_HOLD: cmd_of = CMD_READ;
      WR_CMD, WR_WAIT, WR_HOLD: cmd_of = CMD_WRITE;
      default:                  cmd_of = CMD_IDLE;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    ld_rd     = 1'b0;
    ld_wr     = 1'b0;
    cap_rd    = 1'b0;
    pulse_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.busy) begin
          if (bus.start_read) begin
            state_nxt = RD_CMD;
            ld_rd     = 1'b1;
          end else if (bus.start_write) begin
            state_nxt = WR_CMD;
            ld_wr     = 1'b1;
          end
        end
      end
      RD_CMD:  state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (!bus.busy) begin
          state_nxt = RD_HOLD;
          cap_rd    = 1'b1;
        end
      end
      RD_HOLD: if (!bus.start_read) state_nxt = IDLE;
      WR_CMD:  state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (!bus.busy) begin
          state_nxt = WR_HOLD;
          pulse_wr  = 1'b1;
        end
      end
      WR_HOLD: if (!bus.start_write) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      instr_q      <= CMD_IDLE;
      addr_r_q     <= '0;
      addr_w_q     <= '0;
      data_w_q     <= '0;
      data_r_q     <= '0;
      write_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      instr_q      <= cmd_of(state_nxt);
      write_done_q <= pulse_wr;
      if (ld_rd)  addr_r_q <= bus.addr_r_mc;
      if (ld_wr) begin
        addr_w_q <= bus.addr_w_mc;
        data_w_q <= bus.data_w;
      end
      if (cap_rd) data_r_q <= bus.data_r;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.addr_r      = addr_r_q;
  assign bus.addr_w      = addr_w_q;
  assign bus.data_w_o    = data_w_q;
  assign bus.data_r_o    = data_r_q;
  assign bus.write_done  = write_done_q;

endmodule

// File: tb/tb_read_write.sv
// Directed bench for read_write: reset state, read, write, arbitration, busy stall
// and reset abort, all against hand-computed values.
`timescale 1ns/100ps
module tb_read_write;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  read_write_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  read_write #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".instr"},    32'(bus.instruction), 0);
    check({tag, ".addr_r"},   32'(bus.addr_r),      0);
    check({tag, ".addr_w"},   32'(bus.addr_w),      0);
    check({tag, ".data_w_o"}, 32'(bus.data_w_o),    0);
    check({tag, ".data_r_o"}, 32'(bus.data_r_o),    0);
    check({tag, ".wdone"},    32'(bus.write_done),  0);
  endtask

  initial begin
    bus.busy        = 1'b1;
    bus.start_read  = 1'b0;
    bus.start_write = 1'b0;
    bus.data_r      = 8'd200;
    bus.addr_r_mc   = 8'd50;
    bus.addr_w_mc   = 8'd100;
    bus.data_w      = 8'd255;

    // 1: reset and idle with busy high
    cyc(3);
    n_rst = 1'b1;
    cyc(5);
    check_zero("t1");

    // 2: read
    bus.busy       = 1'b0;
    bus.start_read = 1'b1;
    cyc(5);
    check("t2.instr",    32'(bus.instruction), 1);
    check("t2.addr_r",   32'(bus.addr_r),      50);
    check("t2.data_r_o", 32'(bus.data_r_o),    200);
    bus.start_read = 1'b0;
    cyc(2);
    check("t2.instr_idle", 32'(bus.instruction), 0);
    check("t2.addr_hold",  32'(bus.addr_r),      50);

    // 3: write with pulse counting; pulse expected on the 3rd edge
    bus.start_write = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (bus.write_done) begin
        pulses++;
        check("t3.wdone_lat", 32'(i), 3);
      end
    end
    check("t3.pulses",   32'(pulses),          1);
    check("t3.instr",    32'(bus.instruction), 2);
    check("t3.addr_w",   32'(bus.addr_w),      100);
    check("t3.data_w_o", 32'(bus.data_w_o),    255);
    bus.start_write = 1'b0;
    cyc(2);
    check("t3.instr_idle", 32'(bus.instruction), 0);

    // 4: simultaneous requests, read wins
    bus.addr_r_mc   = 8'd7;
    bus.data_r      = 8'h33;
    bus.addr_w_mc   = 8'hA5;
    bus.data_w      = 8'h5A;
    bus.start_read  = 1'b1;
    bus.start_write = 1'b1;
    cyc(5);
    check("t4.instr_rd", 32'(bus.instruction), 1);
    check("t4.addr_r",   32'(bus.addr_r),      7);
    check("t4.data_r_o", 32'(bus.data_r_o),    8'h33);
    check("t4.addr_w_old", 32'(bus.addr_w),    100);
    bus.start_read = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (bus.write_done) begin
        pulses++;
        check("t4.wdone_lat", 32'(i), 4);
      end
    end
    check("t4.pulses",   32'(pulses),          1);
    check("t4.instr_wr", 32'(bus.instruction), 2);
    check("t4.addr_w",   32'(bus.addr_w),      8'hA5);
    check("t4.data_w_o", 32'(bus.data_w_o),    8'h5A);
    bus.start_write = 1'b0;
    cyc(2);
    check("t4.instr_idle", 32'(bus.instruction), 0);

    // 5: busy stall in RD_WAIT
    bus.addr_r_mc  = 8'd9;
    bus.data_r     = 8'h11;
    bus.start_read = 1'b1;
    cyc(1);
    bus.busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("t5.instr_stall", 32'(bus.instruction), 1);
      check("t5.data_stall",  32'(bus.data_r_o),    8'h33);
    end
    bus.data_r = 8'h44;
    bus.busy   = 1'b0;
    cyc(1);
    check("t5.data_cap", 32'(bus.data_r_o), 8'h44);
    check("t5.addr_r",   32'(bus.addr_r),   9);
    bus.start_read = 1'b0;
    cyc(2);
    check("t5.instr_idle", 32'(bus.instruction), 0);

    // 6: reset during WR_WAIT
    bus.addr_w_mc   = 8'h3C;
    bus.data_w      = 8'hC3;
    bus.start_write = 1'b1;
    cyc(1);
    bus.busy = 1'b1;
    cyc(2);
    check("t6.instr_pre", 32'(bus.instruction), 2);
    #0.5;
    n_rst = 1'b0;
    #0.1;
    check_zero("t6.async");
    bus.start_write = 1'b0;
    bus.busy        = 1'b0;
    pulses = 0;
    repeat (2) begin
      cyc(1);
      if (bus.write_done) pulses++;
    end
    n_rst = 1'b1;
    repeat (4) begin
      cyc(1);
      if (bus.write_done) pulses++;
    end
    check("t6.no_wdone", 32'(pulses), 0);
    check_zero("t6.idle");
    // FSM must be in IDLE: a fresh read lands on exactly the 3rd edge
    bus.data_r     = 8'h77;
    bus.addr_r_mc  = 8'd21;
    bus.start_read = 1'b1;
    cyc(2);
    check("t6.rd_early", 32'(bus.data_r_o), 0);
    cyc(1);
    check("t6.rd_lat",   32'(bus.data_r_o), 8'h77);
    check("t6.addr_r",   32'(bus.addr_r),   21);
    bus.start_read = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
